// File: rtl/demux_d_pkg.sv
// Shared constants and types for the demux_d write-back steering block.
// Default geometry and the channel index type used by the top level.
package demux_d_pkg;

    localparam int DEMUX_D_WIDTH = 4;
    localparam int DEMUX_D_DEPTH = 2;

    typedef logic [0:0] chan_t;

    localparam chan_t CH0 = 1'b0;
    localparam chan_t CH1 = 1'b1;

    // Legal FIFO depth: power of two, at least two entries.
    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/demux_d_fifo.sv
// Synchronous FIFO with separate pointers and an occupancy count.
// Head data is read directly from storage, so a word is visible the cycle after its push.
module demux_d_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push_en;
    logic             pop_en;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign empty     = (cnt == '0);
    assign full      = (cnt == CNT_W'(DEPTH));
    assign push_en   = push & ~full;
    assign pop_en    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            // Simultaneous push and pop leaves the count where it was.
            case ({push_en, pop_en})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/demux_d.sv
// Write-back steering: routes each accepted input word to one of two buffered channels.
// In_Ready depends only on S_D and FIFO state, never on the consumers' ready inputs.
module demux_d
    import demux_d_pkg::*;
#(
    parameter int WIDTH = DEMUX_D_WIDTH,
    parameter int DEPTH = DEMUX_D_DEPTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] In_D,
    input  logic             S_D,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Out_D0,
    output logic             Out_Valid0,
    input  logic             Out_Ready0,
    output logic [WIDTH-1:0] Out_D1,
    output logic             Out_Valid1,
    input  logic             Out_Ready1
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("demux_d: DEPTH must be a power of two and at least 2");
    end

    chan_t sel;
    logic  accept;
    logic  push0;
    logic  push1;
    logic  empty0;
    logic  empty1;
    logic  full0;
    logic  full1;

    assign sel      = S_D;
    assign In_Ready = (sel == CH1) ? ~full1 : ~full0;
    assign accept   = In_Valid & In_Ready;
    assign push0    = accept & (sel == CH0);
    assign push1    = accept & (sel == CH1);

    assign Out_Valid0 = ~empty0;
    assign Out_Valid1 = ~empty1;

    demux_d_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .push      (push0),
        .push_data (In_D),
        .pop       (Out_Ready0),
        .head_data (Out_D0),
        .empty     (empty0),
        .full      (full0)
    );

    demux_d_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .push      (push1),
        .push_data (In_D),
        .pop       (Out_Ready1),
        .head_data (Out_D1),
        .empty     (empty1),
        .full      (full1)
    );

endmodule
